// File: rtl/spi_flash_arbiter.sv
// Shares the flash SPI port between the 6809 read controller and the FT2232 writer.
// Ownership is a registered FSM with a guard gap on every handover and a CPU frame timeout.
module spi_flash_arbiter #(
  parameter int GAP_CYCLES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CPU_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_FT_CS,
  input  logic       i_spi_ce,
  input  logic       i_ctrl_spi_clk,
  input  logic       i_ctrl_spi_mosi,
  input  logic       i_ctrl_spi_cs,
  input  logic       i_wr_spi_clk,
  input  logic       i_wr_spi_mosi,
  input  logic       i_wr_spi_cs,
  output logic       o_SPI_CLK,
  output logic       o_SPI_MOSI,
  output logic       o_SPI_CS,
  output logic       o_ctrl_grant,
  output logic       o_wr_grant,
  output logic       o_halt_n,
  output logic       o_ctrl_abort,
  output logic [1:0] o_owner
);
  localparam int TW = (CPU_TIMEOUT > 1) ? $clog2(CPU_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(CPU_TIMEOUT - 1);
  localparam logic [7:0]    GAP_LOAD = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CTRL = 2'd1,
    S_WR   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                 state, state_d;
  logic                   tgt_wr, tgt_wr_d;
  logic [TW-1:0]          to_cnt, to_cnt_d;
  logic [7:0]             gap_cnt, gap_cnt_d;
  logic                   abort_d;
  logic [SYNC_STAGES-1:0] ft_sync;
  logic [SYNC_STAGES:0]   ft_chain;
  logic                   ft_req, ft_req_d, ctrl_idle;

  // ft_req_d is what ft_req becomes after this edge; it lets HALT track
  // the synchronised request without an extra cycle of lag.
  assign ft_chain  = {ft_sync, i_FT_CS};
  assign ft_req    = ~ft_chain[SYNC_STAGES];
  assign ft_req_d  = ~ft_chain[SYNC_STAGES-1];
  assign ctrl_idle = i_ctrl_spi_cs;

  always_comb begin
    state_d   = state;
    tgt_wr_d  = tgt_wr;
    to_cnt_d  = '0;
    gap_cnt_d = gap_cnt;
    abort_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ft_req)        state_d = S_WR;
        else if (i_spi_ce) state_d = S_CTRL;
      end
      S_CTRL: begin
        if (ft_req && ctrl_idle) begin
          state_d   = S_GAP;
          tgt_wr_d  = 1'b1;
          gap_cnt_d = GAP_LOAD;
        end else if (ft_req) begin
          if (to_cnt == TO_LAST) begin
            state_d   = S_GAP;
            tgt_wr_d  = 1'b1;
            gap_cnt_d = GAP_LOAD;
            abort_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt + 1'b1;
          end
        end else if (!i_spi_ce && ctrl_idle) begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        if (!ft_req) begin
          state_d   = S_GAP;
          tgt_wr_d  = 1'b0;
          gap_cnt_d = GAP_LOAD;
        end
      end
      default: begin
        if (gap_cnt == '0) state_d = (tgt_wr && ft_req) ? S_WR : S_IDLE;
        else               gap_cnt_d = gap_cnt - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      tgt_wr       <= 1'b0;
      to_cnt       <= '0;
      gap_cnt      <= '0;
      ft_sync      <= '1;
      o_ctrl_grant <= 1'b0;
      o_wr_grant   <= 1'b0;
      o_halt_n     <= 1'b1;
      o_ctrl_abort <= 1'b0;
      o_owner      <= 2'd0;
    end else begin
      state        <= state_d;
      tgt_wr       <= tgt_wr_d;
      to_cnt       <= to_cnt_d;
      gap_cnt      <= gap_cnt_d;
      ft_sync      <= ft_chain[SYNC_STAGES-1:0];
      o_ctrl_grant <= (state_d == S_CTRL);
      o_wr_grant   <= (state_d == S_WR);
      o_ctrl_abort <= abort_d;
      o_owner      <= state_d;
      // Every gap involves the writer, so the CPU stays halted until the gap ends.
      o_halt_n     <= !((state_d == S_WR) || (state_d == S_GAP) ||
                        ((state_d == S_CTRL) && ft_req_d));
    end
  end

  always_comb begin
    o_SPI_CS   = 1'b1;
    o_SPI_CLK  = 1'b0;
    o_SPI_MOSI = 1'b0;
    case (state)
      S_CTRL: begin
        o_SPI_CS   = i_ctrl_spi_cs;
        o_SPI_CLK  = i_ctrl_spi_clk;
        o_SPI_MOSI = i_ctrl_spi_mosi;
      end
      S_WR: begin
        o_SPI_CS   = i_wr_spi_cs;
        o_SPI_CLK  = i_wr_spi_clk;
        o_SPI_MOSI = i_wr_spi_mosi;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares the single flash SPI port between the 6809 read controller (spi_flash_controller) and the FT2232 programming path (spi_flash_writer).
- Replaces the combinational i_FT_CS pin mux with a registered ownership FSM.
- Synchronises the asynchronous FT request and never cuts a CPU transaction mid-frame, except on timeout.
- Inserts an idle guard gap on every handover and holds the 6809 in HALT while the writer owns the flash.

Parameters:
GAP_CYCLES, 4, clk cycles of forced idle bus (CS=1, CLK=0, MOSI=0) between owners; legal range 1..255
SYNC_STAGES, 2, flip-flop stages synchronising i_FT_CS into clk
CPU_TIMEOUT, 4096, clk cycles a pending writer request waits on a CPU frame with CS low before forced handover

Ports:
clk  in  1  8 MHz system clock
reset  in  1  asynchronous, active-low
i_FT_CS  in  1  writer request, active-low, asynchronous to clk
i_spi_ce  in  1  CPU flash window decode (address decoder)
i_ctrl_spi_clk / i_ctrl_spi_mosi / i_ctrl_spi_cs  in  1 each  controller SPI drive
i_wr_spi_clk / i_wr_spi_mosi / i_wr_spi_cs  in  1 each  writer SPI drive
o_SPI_CLK / o_SPI_MOSI / o_SPI_CS  out  1 each  flash pins
o_ctrl_grant  out  1  controller owns flash
o_wr_grant  out  1  writer owns flash
o_halt_n  out  1  HALT request to 6809, active-low
o_ctrl_abort  out  1  one-cycle pulse: CPU frame forcibly terminated
o_owner  out  2  0=none, 1=ctrl, 2=writer, 3=gap

Behaviour:
Reset (reset=0, asynchronous):
- State=IDLE. Synchroniser flops load 1 (no request). Counters cleared.
- o_SPI_CS=1, o_SPI_CLK=0, o_SPI_MOSI=0.
- grants=0, o_halt_n=1, o_ctrl_abort=0, o_owner=0.
- Applies immediately, even mid-frame.

Request signals:
- ft_req = inverted output of the last synchroniser stage; latency SYNC_STAGES cycles from an i_FT_CS edge.
- ctrl_idle = i_ctrl_spi_cs==1.

Pin mux:
- Combinational, selected only by registered state.
- CTRL_OWN: controller signals pass through. WR_OWN: writer signals pass through (no clk-domain delay on SCK/MOSI).
- IDLE and GAP: idle levels.

FSM:
- IDLE:
  - ft_req -> WR_OWN.
  - else i_spi_ce -> CTRL_OWN.
  - Both true in the same cycle: writer wins.
- CTRL_OWN:
  - ft_req && ctrl_idle -> GAP, target=WR.
  - ft_req && !ctrl_idle: timeout counter increments each cycle. At CPU_TIMEOUT-1 -> GAP, target=WR, o_ctrl_abort=1 for exactly that transition cycle.
  - !ft_req && !i_spi_ce && ctrl_idle -> IDLE.
  - Timeout counter clears whenever ctrl_idle or !ft_req.
- WR_OWN:
  - !ft_req -> GAP, target=IDLE.
- GAP:
  - Counter loads GAP_CYCLES-1 on entry and decrements; at 0 -> target state.
  - Target WR with ft_req dropped by then -> IDLE instead.
  - Target IDLE: normal IDLE evaluation applies next cycle, so a CPU request waiting in IDLE is granted then.

Registered outputs:
- o_ctrl_grant=1 iff state=CTRL_OWN. o_wr_grant=1 iff state=WR_OWN.
- o_owner follows state: IDLE=0, CTRL_OWN=1, WR_OWN=2, GAP=3.

HALT:
- o_halt_n=0 (registered) when state=WR_OWN, or state=GAP with target=WR, or state=CTRL_OWN && ft_req.
- o_halt_n returns to 1 on the cycle the state leaves GAP toward IDLE.

Boundaries:
- i_FT_CS glitch shorter than SYNC_STAGES cycles may be missed; this is acceptable.
- Writer request dropped while in CTRL_OWN before handover: timeout clears, o_halt_n returns to 1, no gap.
- Counter widths: $clog2(CPU_TIMEOUT) and 8 bits.
- Inputs are never required to meet setup relative to each other; only state is registered.

Test Plan:
1. Reset with all inputs idle -> o_SPI_CS=1, o_SPI_CLK=0, o_halt_n=1, o_owner=0; asserting reset mid-WR_OWN forces the same values in the same cycle.
2. i_spi_ce=1 from IDLE -> o_ctrl_grant=1 after 1 cycle; toggling i_ctrl_spi_clk appears on o_SPI_CLK; i_spi_ce=0 with ctrl CS=1 -> IDLE.
3. i_FT_CS falls during CTRL_OWN while ctrl CS=0 for 20 cycles -> o_halt_n=0 2 cycles after the edge; no handover until ctrl CS rises; then o_owner=3 for 4 cycles, then o_wr_grant=1.
4. Writer pending with ctrl CS stuck low -> exactly one o_ctrl_abort pulse 4096 cycles after ft_req; GAP then WR_OWN follow.
5. i_FT_CS rises while in WR_OWN -> GAP for 4 cycles, then IDLE with o_halt_n=1; i_spi_ce held high -> o_ctrl_grant=1 on the following cycle.
6. i_spi_ce and synchronised ft_req rise in the same IDLE cycle -> WR_OWN entered; o_ctrl_grant stays 0 throughout.
